// File: rtl/arp_frame_tx.sv
// Transmit-side ARP framer. Takes one ARP packet as parallel fields and
// emits an Ethernet header beat plus a 28-byte big-endian ARP payload
// on an 8-bit AXI-Stream. Header and payload handshake independently.
// Optional macro ARP_TX_PAD_EN: zero-pad the payload to 46 bytes.
module arp_frame_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_frame_valid,
  output logic                  s_frame_ready,
  input  logic [47:0]           s_eth_dest_mac,
  input  logic [47:0]           s_eth_src_mac,
  input  logic [15:0]           s_eth_type,
  input  logic [15:0]           s_arp_htype,
  input  logic [15:0]           s_arp_ptype,
  input  logic [7:0]            s_arp_hlen,
  input  logic [7:0]            s_arp_plen,
  input  logic [15:0]           s_arp_oper,
  input  logic [47:0]           s_arp_sha,
  input  logic [31:0]           s_arp_spa,
  input  logic [47:0]           s_arp_tha,
  input  logic [31:0]           s_arp_tpa,
  output logic                  m_eth_hdr_valid,
  input  logic                  m_eth_hdr_ready,
  output logic [47:0]           m_eth_dest_mac,
  output logic [47:0]           m_eth_src_mac,
  output logic [15:0]           m_eth_type,
  output logic [DATA_WIDTH-1:0] m_eth_payload_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_eth_payload_axis_tkeep,
  output logic                  m_eth_payload_axis_tvalid,
  input  logic                  m_eth_payload_axis_tready,
  output logic                  m_eth_payload_axis_tlast,
  output logic                  m_eth_payload_axis_tuser,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  tx_frame_count
);

`ifdef ARP_TX_PAD_EN
  localparam int IDX_W = 6;
  localparam int LAST  = 45;
`else
  localparam int IDX_W = 5;
  localparam int LAST  = 27;
`endif
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LAST);

  typedef enum logic {IDLE, SEND} state_t;

  state_t           state, state_nxt;
  logic [223:0]     pay_sr;   // byte 0 sits in the top 8 bits
  logic [IDX_W-1:0] idx;
  logic             accept, hdr_fire, pay_fire, pay_end;

  assign accept   = s_frame_valid && s_frame_ready;
  assign hdr_fire = m_eth_hdr_valid && m_eth_hdr_ready;
  assign pay_fire = m_eth_payload_axis_tvalid && m_eth_payload_axis_tready;
  assign pay_end  = pay_fire && (idx == LAST_IDX);

  // Shifting left with zero fill also yields the pad bytes when enabled.
  assign m_eth_payload_axis_tdata = pay_sr[223 -: DATA_WIDTH];
  assign m_eth_payload_axis_tkeep = {KEEP_WIDTH{m_eth_payload_axis_tvalid}};
  assign m_eth_payload_axis_tlast = m_eth_payload_axis_tvalid && (idx == LAST_IDX);
  assign m_eth_payload_axis_tuser = 1'b0;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state: leave SEND on the edge that closes the last open channel,
  // so s_frame_ready is back the cycle after the final handshake.
  always_comb begin
    state_nxt     = state;
    s_frame_ready = 1'b0;
    busy          = 1'b0;
    case (state)
      IDLE: begin
        s_frame_ready = 1'b1;
        if (s_frame_valid) state_nxt = SEND;
      end
      SEND: begin
        busy = 1'b1;
        if ((!m_eth_hdr_valid || hdr_fire) &&
            (!m_eth_payload_axis_tvalid || pay_end))
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Header channel: latch on accept, hold valid until sampled ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_eth_hdr_valid <= 1'b0;
      m_eth_dest_mac  <= '0;
      m_eth_src_mac   <= '0;
      m_eth_type      <= '0;
    end else if (accept) begin
      m_eth_hdr_valid <= 1'b1;
      m_eth_dest_mac  <= s_eth_dest_mac;
      m_eth_src_mac   <= s_eth_src_mac;
      m_eth_type      <= s_eth_type;
    end else if (hdr_fire) begin
      m_eth_hdr_valid <= 1'b0;
    end
  end

  // Payload channel: load all fields, shift one byte per handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pay_sr                    <= '0;
      idx                       <= '0;
      m_eth_payload_axis_tvalid <= 1'b0;
    end else if (accept) begin
      pay_sr <= {s_arp_htype, s_arp_ptype, s_arp_hlen, s_arp_plen, s_arp_oper,
                 s_arp_sha, s_arp_spa, s_arp_tha, s_arp_tpa};
      idx                       <= '0;
      m_eth_payload_axis_tvalid <= 1'b1;
    end else if (pay_fire) begin
      pay_sr <= {pay_sr[215:0], 8'h00};
      idx    <= idx + IDX_W'(1);
      if (idx == LAST_IDX) m_eth_payload_axis_tvalid <= 1'b0;
    end
  end

  // Completed-frame counter, bumped when the tlast byte is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       tx_frame_count <= '0;
    else if (pay_end) tx_frame_count <= tx_frame_count + CNT_WIDTH'(1);
  end

endmodule

// File: tb/tb_arp_frame_tx.sv
// Self-checking bench for arp_frame_tx: directed scenarios plus randomized
// frames and backpressure against a byte-queue reference model.
module tb_arp_frame_tx;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_frame_valid, s_frame_ready;
  logic [47:0] s_eth_dest_mac, s_eth_src_mac;
  logic [15:0] s_eth_type, s_arp_htype, s_arp_ptype, s_arp_oper;
  logic [7:0]  s_arp_hlen, s_arp_plen;
  logic [47:0] s_arp_sha, s_arp_tha;
  logic [31:0] s_arp_spa, s_arp_tpa;
  logic        m_eth_hdr_valid, m_eth_hdr_ready;
  logic [47:0] m_eth_dest_mac, m_eth_src_mac;
  logic [15:0] m_eth_type;
  logic [7:0]  tdata;
  logic [0:0]  tkeep;
  logic        tvalid, tready, tlast, tuser, busy;
  logic [15:0] tx_frame_count;

  always #5 clk = ~clk;

  arp_frame_tx dut (
    .clk(clk), .rst_n(rst_n),
    .s_frame_valid(s_frame_valid), .s_frame_ready(s_frame_ready),
    .s_eth_dest_mac(s_eth_dest_mac), .s_eth_src_mac(s_eth_src_mac),
    .s_eth_type(s_eth_type), .s_arp_htype(s_arp_htype),
    .s_arp_ptype(s_arp_ptype), .s_arp_hlen(s_arp_hlen),
    .s_arp_plen(s_arp_plen), .s_arp_oper(s_arp_oper),
    .s_arp_sha(s_arp_sha), .s_arp_spa(s_arp_spa),
    .s_arp_tha(s_arp_tha), .s_arp_tpa(s_arp_tpa),
    .m_eth_hdr_valid(m_eth_hdr_valid), .m_eth_hdr_ready(m_eth_hdr_ready),
    .m_eth_dest_mac(m_eth_dest_mac), .m_eth_src_mac(m_eth_src_mac),
    .m_eth_type(m_eth_type),
    .m_eth_payload_axis_tdata(tdata), .m_eth_payload_axis_tkeep(tkeep),
    .m_eth_payload_axis_tvalid(tvalid), .m_eth_payload_axis_tready(tready),
    .m_eth_payload_axis_tlast(tlast), .m_eth_payload_axis_tuser(tuser),
    .busy(busy), .tx_frame_count(tx_frame_count)
  );

  typedef struct {
    logic [47:0] dmac, smac;
    logic [15:0] etype, htype, ptype;
    logic [7:0]  hlen, plen;
    logic [15:0] oper;
    logic [47:0] sha;
    logic [31:0] spa;
    logic [47:0] tha;
    logic [31:0] tpa;
  } frame_t;

  int          checks = 0;
  int          fails  = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  rx_q[$];
  logic [15:0] exp_count = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference payload: each field pushed most-significant byte first.
  function automatic void push_field(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) exp_q.push_back(8'((v >> (8 * i)) & 64'hFF));
  endfunction

  function automatic void build(input frame_t f);
    exp_q.delete();
    push_field(64'(f.htype), 2); push_field(64'(f.ptype), 2);
    push_field(64'(f.hlen), 1);  push_field(64'(f.plen), 1);
    push_field(64'(f.oper), 2);  push_field(64'(f.sha), 6);
    push_field(64'(f.spa), 4);   push_field(64'(f.tha), 6);
    push_field(64'(f.tpa), 4);
`ifdef ARP_TX_PAD_EN
    for (int i = 0; i < 18; i++) exp_q.push_back(8'h00);
`endif
  endfunction

  function automatic frame_t rnd_frame();
    frame_t f;
    f.dmac = {$urandom, $urandom}; f.smac = {$urandom, $urandom};
    f.etype = 16'h0806; f.htype = 16'($urandom); f.ptype = 16'($urandom);
    f.hlen = 8'($urandom); f.plen = 8'($urandom);
    f.oper = 16'($urandom_range(1, 2));
    f.sha = {$urandom, $urandom}; f.spa = $urandom;
    f.tha = {$urandom, $urandom}; f.tpa = $urandom;
    return f;
  endfunction

  task automatic drive(input frame_t f);
    s_eth_dest_mac = f.dmac; s_eth_src_mac = f.smac; s_eth_type = f.etype;
    s_arp_htype = f.htype; s_arp_ptype = f.ptype; s_arp_hlen = f.hlen;
    s_arp_plen = f.plen; s_arp_oper = f.oper; s_arp_sha = f.sha;
    s_arp_spa = f.spa; s_arp_tha = f.tha; s_arp_tpa = f.tpa;
  endtask

  // Called at a negedge with the DUT idle. bp: 0 always ready, 1 pattern
  // 1,0,0,1, 2 random. hdr_late<0: header ready per bp, else held low until
  // hdr_late cycles after the last byte. b2b keeps valid high with nxt on
  // the inputs. abort_at>=0 pulls reset once that many bytes have gone.
  task automatic run_frame(input frame_t f, input int bp, input int hdr_late,
                           input bit b2b, input frame_t nxt, input int abort_at);
    int k = 0, cyc = 0, after = 0, n;
    bit hdone = 0, pdone = 0, pstall = 0, tr;
    logic [7:0] pd = '0;
    build(f);
    n = exp_q.size();
    rx_q.delete();
    drive(f);
    s_frame_valid = 1'b1;
    chk("idle_ready", 64'(s_frame_ready), 1);
    @(negedge clk);
    if (b2b) drive(nxt);
    else     s_frame_valid = 1'b0;
    chk("hdr_valid_lat", 64'(m_eth_hdr_valid), 1);
    chk("tvalid_lat", 64'(tvalid), 1);
    chk("busy_lat", 64'(busy), 1);
    chk("ready_low", 64'(s_frame_ready), 0);
    chk("dest_mac", 64'(m_eth_dest_mac), 64'(f.dmac));
    chk("src_mac", 64'(m_eth_src_mac), 64'(f.smac));
    chk("eth_type", 64'(m_eth_type), 64'(f.etype));
    while (!(hdone && pdone)) begin
      if (cyc > 800) begin chk("timeout", 0, 1); break; end
      if (abort_at >= 0 && k == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk("rst_hdr_valid", 64'(m_eth_hdr_valid), 0);
        chk("rst_tvalid", 64'(tvalid), 0);
        chk("rst_tlast", 64'(tlast), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_ready", 64'(s_frame_ready), 1);
        chk("rst_count", 64'(tx_frame_count), 0);
        exp_count = '0;
        s_frame_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      case (bp)
        0:       tr = 1'b1;
        1:       tr = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: tr = 1'($urandom_range(0, 1));
      endcase
      tready = tr;
      if (hdr_late < 0) m_eth_hdr_ready = (bp == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
      else              m_eth_hdr_ready = pdone && (after >= hdr_late);
      if (pstall) chk("tdata_stable", 64'(tdata), 64'(pd));
      chk("hdr_valid_state", 64'(m_eth_hdr_valid), 64'(!hdone));
      chk("tvalid_state", 64'(tvalid), 64'(!pdone));
      chk("busy_frame", 64'(busy), 1);
      chk("ready_frame", 64'(s_frame_ready), 0);
      if (m_eth_hdr_valid)
        chk("hdr_stable", 64'(m_eth_dest_mac ^ m_eth_src_mac), 64'(f.dmac ^ f.smac));
      if (tvalid && tr && k < n) begin
        chk("byte", 64'(tdata), 64'(exp_q[k]));
        chk("tlast", 64'(tlast), 64'(k == n - 1));
        chk("tkeep_tuser", 64'({tkeep, tuser}), 64'(2'b10));
        rx_q.push_back(tdata);
        if (k == n - 1) pdone = 1;
        k++;
      end
      if (m_eth_hdr_valid && m_eth_hdr_ready) hdone = 1;
      pstall = tvalid && !tr;
      pd = tdata;
      if (pdone) after++;
      cyc++;
      @(negedge clk);
    end
    exp_count++;
    tready = 1'b0;
    m_eth_hdr_ready = 1'b0;
    chk("end_ready", 64'(s_frame_ready), 1);
    chk("end_busy", 64'(busy), 0);
    chk("end_valids", 64'({m_eth_hdr_valid, tvalid}), 0);
    chk("frame_count", 64'(tx_frame_count), 64'(exp_count));
    chk("byte_total", 64'(rx_q.size()), 64'(n));
  endtask

  initial begin
    frame_t f1, fa, fb, fr, dummy;
    logic [223:0] t1_lit;
    rst_n = 1'b0; s_frame_valid = 1'b0; tready = 1'b0; m_eth_hdr_ready = 1'b0;
    dummy = rnd_frame();
    drive(dummy);
    #1;
    chk("reset_ready", 64'(s_frame_ready), 1);
    chk("reset_outs", 64'({m_eth_hdr_valid, tvalid, tlast, busy, tuser}), 0);
    chk("reset_count", 64'(tx_frame_count), 0);
    chk("reset_hdr", 64'(m_eth_dest_mac | m_eth_src_mac), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: broadcast request
    f1.dmac = 48'hFFFFFFFFFFFF; f1.smac = 48'h5A5152535455; f1.etype = 16'h0806;
    f1.htype = 16'h0001; f1.ptype = 16'h0800; f1.hlen = 8'd6; f1.plen = 8'd4;
    f1.oper = 16'd1; f1.sha = 48'h5A5152535455; f1.spa = 32'hC0A80164;
    f1.tha = 48'h0; f1.tpa = 32'hC0A80165;
    run_frame(f1, 0, -1, 0, dummy, -1);
    t1_lit = 224'h0001_0800_0604_0001_5A5152535455_C0A80164_000000000000_C0A80165;
    if (rx_q.size() >= 28)
      for (int i = 0; i < 28; i++) chk("t1_literal", 64'(rx_q[i]), 64'(t1_lit[223 - 8 * i -: 8]));
    else chk("t1_size", 64'(rx_q.size()), 28);
    chk("t1_count", 64'(tx_frame_count), 1);

    // 2: backpressure 1,0,0,1
    run_frame(rnd_frame(), 1, -1, 0, dummy, -1);
    // 3: late header
    run_frame(rnd_frame(), 0, 10, 0, dummy, -1);
    // 5: mid-frame reset at byte 12, then back-to-back from clean state
    run_frame(rnd_frame(), 0, -1, 0, dummy, 12);
    // 4: back-to-back, oper 2 then oper 1
    fa = rnd_frame(); fa.oper = 16'd2;
    fb = rnd_frame(); fb.oper = 16'd1;
    run_frame(fa, 0, -1, 1, fb, -1);
    chk("b2b_byte7_a", 64'(rx_q.size() > 7 ? rx_q[7] : 8'hXX), 8'h02);
    run_frame(fb, 0, -1, 0, dummy, -1);
    chk("b2b_byte7_b", 64'(rx_q.size() > 7 ? rx_q[7] : 8'hXX), 8'h01);
    chk("b2b_count", 64'(tx_frame_count), 2);

    // randomized frames with random backpressure on both channels
    for (int i = 0; i < 20; i++) begin
      fr = rnd_frame();
      run_frame(fr, 2, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : -1,
                0, dummy, -1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
